// File: rtl/cube_link_pkg.sv
// Shared definitions for the cube row-data link (initiator and responder).
// Frame geometry, header layout and the initiator FSM state encoding.
package cube_link_pkg;

  localparam int ROW_BITS      = 384;
  localparam int BYTES_PER_ROW = 48;
  localparam int FRAME_BYTES   = 49;
  localparam int SWITCH_BITS   = 16;

  localparam logic [1:0] HDR_CMD_ROW = 2'b01;

  localparam int HDR_PANEL_LSB = 6;
  localparam int HDR_ROW_LSB   = 2;
  localparam int HDR_CMD_LSB   = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_HOLD,
    ST_GAP
  } link_state_e;

  function automatic logic [7:0] make_header(
    input logic [1:0] panel,
    input logic [3:0] row
  );
    logic [7:0] h;
    h = '0;
    h[HDR_PANEL_LSB +: 2] = panel;
    h[HDR_ROW_LSB   +: 4] = row;
    h[HDR_CMD_LSB   +: 2] = HDR_CMD_ROW;
    return h;
  endfunction

endpackage

// File: rtl/link_sclk_gen.sv
// Link clock generator: half-period counter, sclk register, rise/fall strobes.
// Ports: clk, reset, count_en, toggle_en in; sclk, tick, rise, fall out.
module link_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  input  logic toggle_en,
  output logic sclk,
  output logic tick,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CMAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Strobes mark the clk edge on which sclk changes.
  assign tick = count_en && (cnt == CMAX);
  assign rise = tick && toggle_en && !sclk;
  assign fall = tick && toggle_en && sclk;

  always_ff @(posedge clk) begin
    if (reset || !count_en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (rise) begin
        sclk <= 1'b1;
      end else if (fall) begin
        sclk <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/row_link_master.sv
// Row-data link initiator: sends a 49-byte frame on miosio, reads 16 switch bits on miso.
// Ports: start_valid/ready handshake, row/addr inputs, busy/done/panel_switches status, link pins.
module row_link_master
  import cube_link_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int IDLE_GAP = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [ROW_BITS-1:0]    row_data,
  input  logic [3:0]             row_addr,
  input  logic [1:0]             panel_addr,
  output logic                   busy,
  output logic                   done,
  output logic [SWITCH_BITS-1:0] panel_switches,
  output logic                   sclk,
  output logic                   ss_n,
  output logic [7:0]             miosio,
  output logic                   miosio_oe,
  input  logic                   miso
);

  localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam logic [GW-1:0] GMAX = GW'(IDLE_GAP - 1);
  localparam logic [5:0] LAST_EDGE = 6'(FRAME_BYTES - 1);
  localparam logic [5:0] SW_EDGES  = 6'(SWITCH_BITS);

  link_state_e state;

  logic [ROW_BITS-1:0]    row_sr;
  logic [SWITCH_BITS-1:0] sw_sr;
  logic [5:0]             edge_cnt;
  logic [GW-1:0]          gap_cnt;

  logic count_en;
  logic toggle_en;
  logic tick;
  logic rise;
  logic fall;

  assign count_en  = (state == ST_SETUP) ||
                     (state == ST_XFER)  ||
                     (state == ST_HOLD);
  assign toggle_en = (state == ST_XFER);

  link_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk (
    .clk       (clk),
    .reset     (reset),
    .count_en  (count_en),
    .toggle_en (toggle_en),
    .sclk      (sclk),
    .tick      (tick),
    .rise      (rise),
    .fall      (fall)
  );

  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (reset) begin
      state       <= ST_IDLE;
      start_ready <= 1'b1;
      busy        <= 1'b0;
      ss_n        <= 1'b1;
      miosio_oe   <= 1'b0;
      miosio      <= '0;
      row_sr      <= '0;
      sw_sr       <= '0;
      edge_cnt    <= '0;
      gap_cnt     <= '0;
      // An aborted frame keeps the last good switch readback.
      if (!busy) begin
        panel_switches <= '0;
      end
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start_valid && start_ready) begin
            state       <= ST_SETUP;
            start_ready <= 1'b0;
            busy        <= 1'b1;
            ss_n        <= 1'b0;
            miosio_oe   <= 1'b1;
            miosio      <= make_header(panel_addr, row_addr);
            row_sr      <= row_data;
            sw_sr       <= '0;
            edge_cnt    <= '0;
          end
        end
        ST_SETUP: begin
          if (tick) begin
            state <= ST_XFER;
          end
        end
        ST_XFER: begin
          // edge_cnt is the byte on the bus, so it equals the rising-edge index.
          if (rise && (edge_cnt < SW_EDGES)) begin
            sw_sr <= {sw_sr[SWITCH_BITS-2:0], miso};
          end
          if (fall) begin
            if (edge_cnt == LAST_EDGE) begin
              state <= ST_HOLD;
            end else begin
              edge_cnt <= edge_cnt + 1'b1;
              miosio   <= row_sr[ROW_BITS-1 -: 8];
              row_sr   <= {row_sr[ROW_BITS-9:0], 8'h00};
            end
          end
        end
        ST_HOLD: begin
          if (tick) begin
            state          <= ST_GAP;
            ss_n           <= 1'b1;
            miosio_oe      <= 1'b0;
            miosio         <= '0;
            done           <= 1'b1;
            panel_switches <= sw_sr;
            gap_cnt        <= '0;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GMAX) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            start_ready <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_row_link_master.sv
// Bench for row_link_master: frame-timing model checked every cycle plus directed cases.
// Second instance runs the fastest legal setting (CLK_DIV=2, IDLE_GAP=1).
module tb_row_link_master;

  localparam int DA = 4;
  localparam int GA = 8;
  localparam int DB = 2;
  localparam int GB = 1;
  localparam int FA = 100 * DA;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;

  logic         sv_a = 1'b0, rdy_a, busy_a, done_a, sclk_a, ss_a, oe_a;
  logic         miso_a = 1'b0;
  logic [383:0] row_a = '0;
  logic [3:0]   raddr_a = '0;
  logic [1:0]   paddr_a = '0;
  logic [15:0]  sw_a;
  logic [7:0]   mio_a;

  logic         sv_b = 1'b0, rdy_b, busy_b, done_b, sclk_b, ss_b, oe_b;
  logic         miso_b = 1'b0;
  logic [383:0] row_b = '0;
  logic [3:0]   raddr_b = 4'h3;
  logic [1:0]   paddr_b = 2'h1;
  logic [15:0]  sw_b;
  logic [7:0]   mio_b;

  row_link_master #(.CLK_DIV(DA), .IDLE_GAP(GA)) dut (
    .clk(clk), .reset(reset),
    .start_valid(sv_a), .start_ready(rdy_a),
    .row_data(row_a), .row_addr(raddr_a), .panel_addr(paddr_a),
    .busy(busy_a), .done(done_a), .panel_switches(sw_a),
    .sclk(sclk_a), .ss_n(ss_a), .miosio(mio_a),
    .miosio_oe(oe_a), .miso(miso_a)
  );

  row_link_master #(.CLK_DIV(DB), .IDLE_GAP(GB)) dut_b (
    .clk(clk), .reset(reset),
    .start_valid(sv_b), .start_ready(rdy_b),
    .row_data(row_b), .row_addr(raddr_b), .panel_addr(paddr_b),
    .busy(busy_b), .done(done_b), .panel_switches(sw_b),
    .sclk(sclk_b), .ss_n(ss_b), .miosio(mio_b),
    .miosio_oe(oe_b), .miso(miso_b)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      if (errs < 40)
        $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [383:0] rnd_row();
    logic [383:0] r;
    for (int i = 0; i < 12; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Model: t counts clk edges since the accepting edge (-1 = no frame).
  int           t = -1;
  int           acc_cnt = 0;
  logic [383:0] m_row = '0;
  logic [7:0]   m_hdr = '0;
  logic [15:0]  m_sw = '0;
  logic [15:0]  cur_pat = '0;
  logic [15:0]  pat = '0;
  bit           chk_on = 1'b0;
  bit           rst_done = 1'b0;
  bit           b_fin = 1'b0;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      if (!(t >= 0 && t < FA + GA)) m_sw = '0;
      t = -1;
    end else if (t < 0 || t >= FA + GA) begin
      if (sv_a) begin
        t = 0;
        m_row = row_a;
        m_hdr = {paddr_a, raddr_a, 2'b01};
        cur_pat = pat;
        acc_cnt++;
      end else begin
        t = -1;
      end
    end else begin
      t++;
      if (t == FA) m_sw = cur_pat;
    end
  end

  // Responder: bit for rising edge k is presented before that edge.
  initial forever begin
    @(negedge clk);
    if (t >= 0 && t / (2 * DA) < 16)
      miso_a = cur_pat[15 - t / (2 * DA)];
    else
      miso_a = 1'b0;
  end

  function automatic logic [7:0] fbyte(input int b);
    if (b == 0) return m_hdr;
    return m_row[383 - 8 * (b - 1) -: 8];
  endfunction

  logic        e_frame, e_busy, e_sclk;
  logic [7:0]  e_mio;
  int          e_b;

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      e_frame = (t >= 0) && (t < FA);
      e_busy  = (t >= 0) && (t < FA + GA);
      e_sclk  = (t >= 2 * DA) && (t < FA) && (((t - 2 * DA) / DA) % 2 == 0);
      e_b     = (t < 3 * DA) ? 0 : (t - 3 * DA) / (2 * DA) + 1;
      if (e_b > 48) e_b = 48;
      e_mio   = e_frame ? fbyte(e_b) : 8'h00;
      chk("busy_rdy_done_ssn_oe_sclk_mio_sw",
          {busy_a, rdy_a, done_a, ss_a, oe_a, sclk_a, mio_a, sw_a},
          {e_busy, !e_busy, t == FA, !e_frame, e_frame, e_sclk,
           e_mio, m_sw});
    end
  end

  logic [7:0] rxq[$];
  int   done_cnt = 0;
  int   ss_run = 0;
  int   last_run = 0;
  logic prev_sclk = 1'b0;

  initial forever begin
    @(negedge clk);
    if (sclk_a && !prev_sclk) rxq.push_back(mio_a);
    prev_sclk = sclk_a;
    if (done_a) done_cnt++;
    if (ss_a) begin
      ss_run++;
    end else begin
      if (ss_run > 0) last_run = ss_run;
      ss_run = 0;
    end
  end

  task automatic start_frame();
    int a0, n;
    a0 = acc_cnt;
    sv_a = 1'b1;
    n = 0;
    while (acc_cnt == a0 && n < 1000) begin
      step();
      n++;
    end
    chk("accept_seen", 64'(acc_cnt - a0), 1);
    sv_a = 1'b0;
    row_a = ~row_a;
    raddr_a = ~raddr_a;
    paddr_a = ~paddr_a;
  endtask

  task automatic wait_flag(input bit want_done, inout int n);
    while (!(want_done ? done_a : rdy_a) && n < 2000) begin
      step();
      n++;
    end
  endtask

  logic [15:0] pats [3] = '{16'h3C5A, 16'hFFFF, 16'h8001};

  initial begin
    int n, d0, a0;
    repeat (2) step();
    chk_on = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    rst_done = 1'b1;
    repeat (20) step();
    chk("idle_ss_n", 64'(ss_a), 1);
    chk("idle_sclk", 64'(sclk_a), 0);
    chk("idle_oe", 64'(oe_a), 0);
    chk("idle_ready", 64'(rdy_a), 1);
    chk("idle_done_cnt", 64'(done_cnt), 0);
    chk("idle_sw", 64'(sw_a), 0);

    for (int i = 0; i < 48; i++) row_a[383 - 8 * i -: 8] = 8'(i + 1);
    paddr_a = 2'd2;
    raddr_a = 4'd5;
    pat = 16'hA5C3;
    rxq.delete();
    start_frame();
    n = 0;
    wait_flag(1'b1, n);
    chk("done_latency", 64'(n), 400);
    chk("done_sw", 64'(sw_a), 16'hA5C3);
    wait_flag(1'b0, n);
    chk("ready_latency", 64'(n), 408);
    chk("rise_count", 64'(rxq.size()), 49);
    chk("rx_header", 64'(rxq.size() > 0 ? rxq[0] : 8'h00), 8'h95);
    for (int k = 1; k < 49; k++)
      chk("rx_byte", 64'(k < rxq.size() ? rxq[k] : 8'h00), 64'(k));
    chk("done_pulses_f1", 64'(done_cnt), 1);

    row_a = rnd_row();
    paddr_a = 2'd1;
    raddr_a = 4'd10;
    pat = 16'h0000;
    start_frame();
    n = 0;
    wait_flag(1'b1, n);
    chk("zero_sw", 64'(sw_a), 0);
    wait_flag(1'b0, n);

    d0 = done_cnt;
    row_a = rnd_row();
    pat = pats[0];
    sv_a = 1'b1;
    for (int f = 0; f < 3; f++) begin
      a0 = acc_cnt;
      n = 0;
      while (acc_cnt == a0 && n < 1000) begin
        step();
        n++;
      end
      chk("b2b_accept", 64'(acc_cnt - a0), 1);
      if (f > 0) chk("b2b_gap_run", 64'(last_run), GA + 1);
      row_a = ~row_a;
      if (f < 2) begin
        pat = pats[f + 1];
        repeat (200) step();
        row_a = rnd_row();
        raddr_a = raddr_a + 4'd3;
        paddr_a = paddr_a + 2'd1;
      end else begin
        sv_a = 1'b0;
      end
    end
    n = 0;
    while (done_cnt < d0 + 3 && n < 3000) begin
      step();
      n++;
    end
    repeat (50) step();
    chk("b2b_done_cnt", 64'(done_cnt - d0), 3);
    chk("b2b_sw", 64'(sw_a), 16'h8001);

    row_a = rnd_row();
    pat = 16'h1234;
    start_frame();
    repeat (170) step();
    reset = 1'b1;
    step();
    chk("abort_ss_n", 64'(ss_a), 1);
    chk("abort_sclk", 64'(sclk_a), 0);
    chk("abort_oe", 64'(oe_a), 0);
    reset = 1'b0;
    d0 = done_cnt;
    repeat (500) step();
    chk("abort_no_done", 64'(done_cnt - d0), 0);
    chk("abort_sw", 64'(sw_a), 16'h8001);

    row_a = rnd_row();
    pat = 16'h0F0F;
    start_frame();
    n = 0;
    wait_flag(1'b1, n);
    chk("after_abort_latency", 64'(n), 400);
    chk("after_abort_sw", 64'(sw_a), 16'h0F0F);
    wait_flag(1'b0, n);

    n = 0;
    while (!b_fin && n < 1000) begin
      step();
      n++;
    end
    chk("b_finished", 64'(b_fin), 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    int n, r1, r2, rises;
    logic pv;
    n = 0;
    while (!rst_done && n < 100) begin
      step();
      n++;
    end
    step();
    row_b = rnd_row();
    sv_b = 1'b1;
    n = 0;
    while (!busy_b && n < 50) begin
      step();
      n++;
    end
    chk("b_accept", 64'(busy_b), 1);
    sv_b = 1'b0;
    n = 0;
    r1 = -1;
    r2 = -1;
    rises = 0;
    pv = sclk_b;
    while (!done_b && n < 1000) begin
      step();
      n++;
      if (sclk_b && !pv) begin
        rises++;
        if (r1 < 0) r1 = n;
        else if (r2 < 0) r2 = n;
      end
      pv = sclk_b;
    end
    chk("b_done_latency", 64'(n), 100 * DB);
    chk("b_first_rise", 64'(r1), 2 * DB);
    chk("b_sclk_period", 64'(r2 - r1), 2 * DB);
    chk("b_rises", 64'(rises), 49);
    while (!rdy_b && n < 1000) begin
      step();
      n++;
    end
    chk("b_ready_latency", 64'(n), 100 * DB + GB);
    chk("b_idle_pins", {ss_b, oe_b, busy_b, mio_b, sw_b}, {3'b100, 8'h00, 16'h0000});
    b_fin = 1'b1;
  end

endmodule
